// File: rtl/conv_encoder_punct.sv
// Parametrised convolutional encoder with zero-tail frames and puncturing.
// Valid/ready on both sides, single-stage registered output.
module conv_encoder_punct #(
    parameter int              K       = 9,
    parameter int              N       = 2,
    parameter logic [N*K-1:0]  G       = {9'o561, 9'o753},
    parameter bit              TAIL_EN = 1'b1
) (
    input  logic         CLOCK,
    input  logic         Reset,
    input  logic [1:0]   Mode,
    input  logic         InData,
    input  logic         InValid,
    input  logic         InLast,
    output logic         InReady,
    output logic [N-1:0] Code,
    output logic [N-1:0] CodeMask,
    output logic         OutValid,
    output logic         OutLast,
    input  logic         OutReady
);

    localparam int TW = (K > 2) ? $clog2(K - 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [K-2:0]   sr;
    logic [1:0]     punct_cnt;
    logic [1:0]     mode_q;
    logic [TW-1:0]  tail_cnt;

    logic           adv;
    logic           accept;
    logic           tail_step;
    logic           tail_done;
    logic           produce;
    logic           last_sym;
    logic           enc_bit;
    logic [1:0]     mode_eff;
    logic [1:0]     pidx;
    logic [1:0]     pidx_nxt;
    logic [1:0]     pm;
    logic [N-1:0]   mask;
    logic [K-1:0]   v;
    logic [N-1:0]   code_raw;

    // State register
    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: frame start, last bit, tail countdown
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DATA: begin
                if (accept & InLast) state_nxt = TAIL_EN ? TAIL : IDLE;
                else if (accept)     state_nxt = DATA;
            end
            TAIL: begin
                if (tail_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: handshake, symbol production and the bit being encoded
    always_comb begin
        adv       = ~OutValid | OutReady;
        InReady   = adv & ~Reset & ((state == IDLE) | (state == DATA));
        accept    = InValid & InReady;
        tail_step = adv & (state == TAIL);
        tail_done = tail_step & (tail_cnt == TW'(K - 2));
        produce   = accept | tail_step;
        enc_bit   = accept & InData;
        last_sym  = tail_done | (accept & InLast & ~TAIL_EN);
    end

    // Puncture pattern: a new frame starts at phase 0 with the live Mode
    always_comb begin
        mode_eff = (state == IDLE) ? ((Mode == 2'd3) ? 2'd0 : Mode) : mode_q;
        pidx     = (state == IDLE) ? 2'd0 : punct_cnt;
        pm       = 2'b11;
        pidx_nxt = 2'd0;
        unique case (mode_eff)
            2'd1: begin
                pm       = pidx[0] ? 2'b10 : 2'b11;
                pidx_nxt = {1'b0, ~pidx[0]};
            end
            2'd2: begin
                pm       = (pidx == 2'd0) ? 2'b11 :
                           (pidx == 2'd1) ? 2'b10 : 2'b01;
                pidx_nxt = (pidx == 2'd2) ? 2'd0 : pidx + 2'd1;
            end
            default: begin
                pm       = 2'b11;
                pidx_nxt = 2'd0;
            end
        endcase
    end

    if (N == 2) begin : g_punct
        assign mask = pm;
    end else begin : g_nopunct
        assign mask = '1;
    end

    // Generator parities over the current bit and the shift register
    always_comb begin
        v        = {enc_bit, sr};
        code_raw = '0;
        for (int j = 0; j < N; j++) begin
            code_raw[N-1-j] = ^(G[(N-j)*K-1 -: K] & v);
        end
    end

    // Encoder state: shift register, puncture phase, tail count, frame mode
    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            sr        <= '0;
            punct_cnt <= 2'd0;
            tail_cnt  <= '0;
            mode_q    <= 2'd0;
        end else begin
            if (accept & (state == IDLE)) mode_q <= mode_eff;
            if (produce) begin
                punct_cnt <= pidx_nxt;
                sr        <= last_sym ? '0 : v[K-1:1];
            end
            if (tail_done)      tail_cnt <= '0;
            else if (tail_step) tail_cnt <= tail_cnt + TW'(1);
        end
    end

    // Output register: load a new symbol or drop valid whenever it may advance
    always_ff @(posedge CLOCK or posedge Reset) begin
        if (Reset) begin
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
            Code     <= '0;
            CodeMask <= '0;
        end else if (adv) begin
            OutValid <= produce;
            OutLast  <= produce & last_sym;
            if (produce) begin
                Code     <= code_raw & mask;
                CodeMask <= mask;
            end
        end
    end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Bench for conv_encoder_punct: scoreboard of expected symbols
// filled on input acceptance, drained as the encoder emits.
module tb_conv_encoder_punct;

    typedef struct packed {
        logic [1:0] c;
        logic [1:0] m;
        logic       l;
    } sym_t;

    logic       CLOCK = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       in_data, in_valid, in_last, out_ready;
    logic       in_ready, out_valid, out_last;
    logic [1:0] code, code_mask;

    logic       nt_valid, nt_data, nt_last;
    logic       nt_ready, nt_ov, nt_ol;
    logic [1:0] nt_code, nt_mask;

    int checks = 0;
    int errors = 0;

    sym_t       sb[$];
    logic [1:0] seen_c[$];
    logic [1:0] seen_m[$];
    logic       seen_l[$];

    logic [7:0] sr_m;
    logic [1:0] mode_m;
    int         pcnt_m;
    bit         in_frame;
    bit         acc_prev, acc_last, stall_prev, chk_tail;
    logic [1:0] held_c, held_m;
    logic       held_l;

    logic [1:0] imp_c [9] = '{2'b11, 2'b01, 2'b11, 2'b11, 2'b10,
                              2'b01, 2'b00, 2'b01, 2'b11};
    logic [1:0] m2_c  [9] = '{2'b11, 2'b00, 2'b01, 2'b11, 2'b10,
                              2'b01, 2'b00, 2'b00, 2'b01};
    logic [1:0] m2_m  [9] = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b10,
                              2'b01, 2'b11, 2'b10, 2'b01};
    logic [5:0] b5 = 6'b101101;

    always #5 CLOCK = ~CLOCK;

    conv_encoder_punct dut (
        .CLOCK    (CLOCK),
        .Reset    (rst),
        .Mode     (mode),
        .InData   (in_data),
        .InValid  (in_valid),
        .InLast   (in_last),
        .InReady  (in_ready),
        .Code     (code),
        .CodeMask (code_mask),
        .OutValid (out_valid),
        .OutLast  (out_last),
        .OutReady (out_ready)
    );

    conv_encoder_punct #(.TAIL_EN(1'b0)) dut_nt (
        .CLOCK    (CLOCK),
        .Reset    (rst),
        .Mode     (mode),
        .InData   (nt_data),
        .InValid  (nt_valid),
        .InLast   (nt_last),
        .InReady  (nt_ready),
        .Code     (nt_code),
        .CodeMask (nt_mask),
        .OutValid (nt_ov),
        .OutLast  (nt_ol),
        .OutReady (out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] mask_tab(input logic [1:0] m,
                                            input int p);
        if (m == 2'd1) return (p == 0) ? 2'b11 : 2'b10;
        if (m == 2'd2) return (p == 0) ? 2'b11 : (p == 1) ? 2'b10 : 2'b01;
        return 2'b11;
    endfunction

    function automatic int period(input logic [1:0] m);
        return (m == 2'd1) ? 2 : (m == 2'd2) ? 3 : 1;
    endfunction

    function automatic void push_sym(input logic b, input logic l);
        logic [8:0] v;
        sym_t       s;
        v   = {b, sr_m};
        s.m = mask_tab(mode_m, pcnt_m);
        s.c = {^(9'o561 & v), ^(9'o753 & v)} & s.m;
        s.l = l;
        sb.push_back(s);
        sr_m   = v[8:1];
        pcnt_m = (pcnt_m + 1) % period(mode_m);
    endfunction

    function automatic void model_accept(input logic b, input logic last);
        if (!in_frame) begin
            mode_m   = (mode == 2'd3) ? 2'd0 : mode;
            pcnt_m   = 0;
            in_frame = 1'b1;
        end
        push_sym(b, 1'b0);
        if (last) begin
            for (int i = 0; i < 8; i++) push_sym(1'b0, i == 7);
            in_frame = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        sr_m       = '0;
        mode_m     = 2'd0;
        pcnt_m     = 0;
        in_frame   = 1'b0;
        acc_prev   = 1'b0;
        acc_last   = 1'b0;
        stall_prev = 1'b0;
    endfunction

    function automatic void seen_clear();
        seen_c.delete();
        seen_m.delete();
        seen_l.delete();
    endfunction

    task automatic step();
        sym_t s;
        @(negedge CLOCK);
        if (acc_prev) chk("latency_valid", 32'(out_valid), 1);
        if (stall_prev) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_code", 32'(code), 32'(held_c));
            chk("stall_mask", 32'(code_mask), 32'(held_m));
            chk("stall_last", 32'(out_last), 32'(held_l));
        end
        if (out_valid && !out_ready) chk("stall_inready", 32'(in_ready), 0);
        if (chk_tail && out_valid && sb.size() > 1)
            chk("tail_inready", 32'(in_ready), 0);
        if (out_valid && out_ready) begin
            chk("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                s = sb.pop_front();
                chk("sb_code", 32'(code), 32'(s.c));
                chk("sb_mask", 32'(code_mask), 32'(s.m));
                chk("sb_last", 32'(out_last), 32'(s.l));
                seen_c.push_back(code);
                seen_m.push_back(code_mask);
                seen_l.push_back(out_last);
            end
        end
        acc_last = in_valid && in_ready;
        if (acc_last) model_accept(in_data, in_last);
        stall_prev = out_valid && !out_ready;
        held_c     = code;
        held_m     = code_mask;
        held_l     = out_last;
        acc_prev   = acc_last;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drain(input int maxc);
        int n;
        n = 0;
        while (sb.size() > 0 && n < maxc) begin
            step();
            n++;
        end
        chk("drain_done", 32'(sb.size()), 0);
    endtask

    task automatic send_impulse(input logic [1:0] md);
        mode     = md;
        in_data  = 1'b1;
        in_last  = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_impulse(input string tag);
        chk({tag, "_count"}, 32'(seen_c.size()), 9);
        for (int i = 0; i < 9 && i < seen_c.size(); i++) begin
            chk($sformatf("%s_code%0d", tag, i), 32'(seen_c[i]), 32'(imp_c[i]));
            chk($sformatf("%s_mask%0d", tag, i), 32'(seen_m[i]), 3);
            chk($sformatf("%s_last%0d", tag, i), 32'(seen_l[i]), 32'(i == 8));
        end
    endtask

    task automatic nt_send(input logic b, input logic l,
                           input logic [1:0] ec, input logic el);
        @(posedge CLOCK);
        #1;
        nt_data  = b;
        nt_last  = l;
        nt_valid = 1'b1;
        @(negedge CLOCK);
        chk("nt_inready", 32'(nt_ready), 1);
        @(posedge CLOCK);
        #1;
        nt_valid = 1'b0;
        @(negedge CLOCK);
        chk("nt_valid", 32'(nt_ov), 1);
        chk("nt_code", 32'(nt_code), 32'(ec));
        chk("nt_mask", 32'(nt_mask), 3);
        chk("nt_last", 32'(nt_ol), 32'(el));
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        mode      = 2'd0;
        in_data   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        nt_valid  = 1'b0;
        nt_data   = 1'b0;
        nt_last   = 1'b0;
        chk_tail  = 1'b0;
        model_reset();

        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_mask", 32'(code_mask), 0);
        chk("rst_inready", 32'(in_ready), 0);
        rst = 1'b0;
        @(posedge CLOCK);
        #1;
        chk("idle_inready", 32'(in_ready), 1);

        // impulse, rate 1/2
        seen_clear();
        chk_tail = 1'b1;
        send_impulse(2'd0);
        drain(30);
        chk_tail = 1'b0;
        check_impulse("s1");

        // three ones back to back
        seen_clear();
        mode     = 2'd0;
        in_data  = 1'b1;
        in_valid = 1'b1;
        repeat (3) step();
        in_data = 1'b0;
        in_last = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain(30);
        chk("s2_code0", 32'(seen_c[0]), 32'(2'b11));
        chk("s2_code1", 32'(seen_c[1]), 32'(2'b10));
        chk("s2_code2", 32'(seen_c[2]), 32'(2'b01));

        // impulse, rate 3/4; Mode change mid-frame is ignored
        seen_clear();
        send_impulse(2'd2);
        mode = 2'd1;
        drain(30);
        chk("s3_count", 32'(seen_c.size()), 9);
        for (int i = 0; i < 9 && i < seen_c.size(); i++) begin
            chk($sformatf("s3_code%0d", i), 32'(seen_c[i]), 32'(m2_c[i]));
            chk($sformatf("s3_mask%0d", i), 32'(seen_m[i]), 32'(m2_m[i]));
        end

        // backpressure and a bubble, rate 2/3
        mode = 2'd1;
        for (int i = 0; i < 6; i++) begin
            in_data  = b5[5-i];
            in_last  = (i == 5);
            in_valid = 1'b1;
            if (i == 2) begin
                out_ready = 1'b0;
                repeat (5) step();
                out_ready = 1'b1;
            end
            if (i == 4) begin
                in_valid = 1'b0;
                step();
                in_valid = 1'b1;
            end
            acc_last = 1'b0;
            n = 0;
            while (!acc_last && n < 10) begin
                step();
                n++;
            end
            chk($sformatf("s5_accept%0d", i), 32'(acc_last), 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) step();
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
        drain(40);

        // reset in the middle of the tail
        send_impulse(2'd0);
        repeat (5) step();
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_last", 32'(out_last), 0);
        chk("mid_rst_mask", 32'(code_mask), 0);
        chk("mid_rst_inready", 32'(in_ready), 0);
        sb.delete();
        model_reset();
        @(posedge CLOCK);
        @(negedge CLOCK);
        rst = 1'b0;
        @(posedge CLOCK);
        #1;
        seen_clear();
        send_impulse(2'd3);
        drain(30);
        check_impulse("s6");

        // truncated frames on the TAIL_EN=0 instance
        mode = 2'd0;
        nt_send(1'b1, 1'b0, 2'b11, 1'b0);
        nt_send(1'b0, 1'b0, 2'b01, 1'b0);
        nt_send(1'b1, 1'b1, 2'b00, 1'b1);
        nt_send(1'b1, 1'b1, 2'b11, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_encoder_punct.md
Name: conv_encoder_punct

Overview:
- Parametrised successor to the fixed K=9, rate-1/2 convolutional encoder that drives VITERBIDECODER.
- Adds generic constraint length K, N output bits per input and generator polynomials.
- Adds frame handling with zero-tail termination, runtime puncturing (rate 1/2, 2/3, 3/4) with per-bit erasure mask, and valid/ready handshakes on both sides.
- Sits between the data source and the channel/decoder.

Parameters:
- K, 9, constraint length (2..16); shift register holds K-1 past bits.
- N, 2, output bits per input bit (WD_CODE); puncturing supported only when N==2.
- G, {9'o561, 9'o753}, N*K-bit concatenated generators. Slice j = G[(N-j)*K-1 -: K] drives Code[N-1-j], so Code[1] uses 561 and Code[0] uses 753.
- TAIL_EN, 1, 1 = append K-1 zero tail bits per frame; 0 = truncated frames.

Ports:
- CLOCK  in  1  single clock, rising edge.
- Reset  in  1  reset, asynchronous, active-high.
- Mode  in  2  puncture mode: 0 = 1/2, 1 = 2/3, 2 = 3/4, 3 = treated as 0; sampled at frame start.
- InData  in  1  information bit.
- InValid  in  1  InData valid.
- InLast  in  1  marks last information bit of frame.
- InReady  out  1  encoder accepts InData this cycle.
- Code  out  N  coded symbol; punctured bits forced 0.
- CodeMask  out  N  1 = bit transmitted, 0 = erasure.
- OutValid  out  1  Code/CodeMask valid.
- OutLast  out  1  final symbol of frame (last tail symbol when TAIL_EN=1).
- OutReady  in  1  downstream accepts symbol.

Behaviour:
- Reset (async, any time including mid-frame):
  - sr = 0, state = IDLE, punct_cnt = 0, tail_cnt = 0, mode_q = 0.
  - OutValid = 0, OutLast = 0, Code = 0, CodeMask = 0, InReady = 0 while Reset is high.
  - Partial frame is discarded.
- Output register:
  - Single stage. adv = ~OutValid | OutReady.
  - Symbol held stable while OutValid & ~OutReady.
- InReady = adv & (state==IDLE | state==DATA).
- Encoding:
  - v = {bit, sr}, where bit is the current input (MSB of v).
  - Code[N-1-j] = ^(Gj & v), then ANDed with the mask bit.
  - On each produced symbol: sr <= {bit, sr[K-2:1]}.
  - Latency: input accepted at edge t appears on Code with OutValid=1 after edge t (one cycle).
- FSM:
  - IDLE: on InValid & InReady, latch mode_q = Mode (3 maps to 0), punct_cnt = 0, encode the bit, go DATA. If InLast is also set, go TAIL (TAIL_EN=1) or stay IDLE (TAIL_EN=0).
  - DATA: each accepted bit produces one symbol. InLast accepted -> TAIL (TAIL_EN=1), or IDLE with sr cleared to 0 (TAIL_EN=0). With TAIL_EN=0, that symbol carries OutLast.
  - TAIL: InReady=0. When adv, emit one symbol with bit=0, incrementing tail_cnt. The (K-1)th tail symbol carries OutLast=1 and moves to IDLE. sr is then 0 naturally; tail_cnt is cleared.
  - Mode changes outside IDLE-accept are ignored.
- Puncturing (N==2):
  - mode 0: mask 11 always.
  - mode 1 (period 2): masks 11, 10.
  - mode 2 (period 3): masks 11, 10, 01.
  - punct_cnt advances per produced symbol (data and tail) and wraps at the period.
  - When N!=2, mask is all ones regardless of Mode.
- Bubbles:
  - InValid low in DATA: OutValid drops after the held symbol is accepted; no state change.
  - OutReady low stalls everything, including TAIL.
- Frame-to-frame: a new frame can be accepted in the cycle after OutLast's symbol is produced (IDLE). No gap is required beyond the FSM return.

Test Plan:
- Reset, Mode=0, TAIL_EN=1, send single bit 1 with InLast, OutReady=1 -> 9 symbols: 11,01,11,11,10,01,00,01,11. CodeMask=11 throughout; OutLast only on the 9th; InReady=0 during tail.
- Mode=0, send 1,1,1 (no InLast yet) -> Code 11, 10, 01, each one cycle after acceptance.
- Mode=2, same impulse frame -> CodeMask sequence 11,10,01,11,10,01,11,10,01. Code = impulse values ANDed with mask: 11,00,01,11,10,01,00,00,01.
- Backpressure: hold OutReady=0 for 5 cycles mid-frame -> Code/CodeMask/OutLast stable, InReady=0, no symbol lost or duplicated; sequence identical to the unstalled run.
- Assert Reset during TAIL (after 4 tail symbols) -> OutValid=0 immediately (asynchronously). After release, a new impulse frame reproduces the first scenario exactly (sr and punct_cnt cleared).
- TAIL_EN=0, frame 1,0,1 with InLast on the third bit -> 3 symbols, OutLast on the 3rd. A following frame starting with bit 1 yields 11 (sr cleared).
